// File: rtl/rs_issue_scheduler_pkg.sv
// Shared sizing, FSM encoding and index helpers for the reservation-station issue scheduler.
package rs_issue_scheduler_pkg;

    localparam int NUM_RS   = 4;
    localparam int IDX_BITS = 2;
    localparam int CNT_BITS = 3;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        ISSUE = 1'b1
    } issue_state_e;

    function automatic logic [NUM_RS-1:0] idx_onehot(input logic [IDX_BITS-1:0] idx);
        logic [NUM_RS-1:0] vec;
        vec      = {NUM_RS{1'b0}};
        vec[idx] = 1'b1;
        return vec;
    endfunction

    // Increment modulo NUM_RS, safe when NUM_RS is not a power of two.
    function automatic logic [IDX_BITS-1:0] idx_inc(input logic [IDX_BITS-1:0] idx);
        logic [IDX_BITS-1:0] nxt;
        if (idx == IDX_BITS'(NUM_RS - 1)) begin
            nxt = IDX_BITS'(0);
        end else begin
            nxt = idx + IDX_BITS'(1);
        end
        return nxt;
    endfunction

endpackage

// File: rtl/rs_issue_scheduler_if.sv
// Dispatch, entry-status and FU issue signals between the scheduler (master) and its
// reservation-station bank / functional unit (slave).
interface rs_issue_scheduler_if;
    import rs_issue_scheduler_pkg::*;

    logic                dispatch_valid_in;
    logic                dispatch_stall_out;
    logic [NUM_RS-1:0]   rs_load_out;
    logic [NUM_RS-1:0]   rs_avail_in;
    logic [NUM_RS-1:0]   rs_ready_in;
    logic [NUM_RS-1:0]   rs_use_enable_out;
    logic [NUM_RS-1:0]   rs_free_out;
    logic                fu_ready_in;
    logic                issue_valid_out;
    logic [IDX_BITS-1:0] issue_idx_out;
    logic                flush_in;
    logic [CNT_BITS-1:0] occupancy_out;

    modport master (
        input  dispatch_valid_in, rs_avail_in, rs_ready_in, fu_ready_in, flush_in,
        output dispatch_stall_out, rs_load_out, rs_use_enable_out, rs_free_out,
               issue_valid_out, issue_idx_out, occupancy_out
    );

    modport slave (
        output dispatch_valid_in, rs_avail_in, rs_ready_in, fu_ready_in, flush_in,
        input  dispatch_stall_out, rs_load_out, rs_use_enable_out, rs_free_out,
               issue_valid_out, issue_idx_out, occupancy_out
    );

endinterface

// File: rtl/rs_issue_scheduler_rr_picker.sv
// Combinational round-robin select: first requesting, non-excluded index at or after start_s.
module rs_issue_scheduler_rr_picker
    import rs_issue_scheduler_pkg::*;
(
    input  logic [NUM_RS-1:0]   req_s,
    input  logic [IDX_BITS-1:0] start_s,
    input  logic [NUM_RS-1:0]   exclude_s,
    output logic                valid_s,
    output logic [IDX_BITS-1:0] idx_s
);

    logic [NUM_RS-1:0]   cand_s;
    logic [IDX_BITS-1:0] pos_s;
    logic                hit_s;

    // Walk the ring from start_s and latch the first candidate seen.
    always_comb begin
        cand_s  = req_s & ~exclude_s;
        valid_s = 1'b0;
        idx_s   = IDX_BITS'(0);
        pos_s   = start_s;
        hit_s   = 1'b0;
        for (int i = 0; i < NUM_RS; i++) begin
            hit_s   = ~valid_s & cand_s[pos_s];
            idx_s   = hit_s ? pos_s : idx_s;
            valid_s = valid_s | hit_s;
            pos_s   = idx_inc(pos_s);
        end
    end

endmodule

// File: rtl/rs_issue_scheduler.sv
// Reservation-station bank controller: lowest-index allocation, round-robin issue FSM
// with FU handshake, per-entry free strobes, flush and a registered occupancy count.
module rs_issue_scheduler
    import rs_issue_scheduler_pkg::*;
(
    input  logic                 clock,
    input  logic                 reset,
    rs_issue_scheduler_if.master bus
);

    issue_state_e        state_r, state_nxt_s;
    logic [IDX_BITS-1:0] sel_idx_r, sel_idx_nxt_s;
    logic [IDX_BITS-1:0] rr_ptr_r, rr_ptr_nxt_s;
    logic [CNT_BITS-1:0] occ_r, occ_nxt_s;

    logic                stall_s;
    logic [NUM_RS-1:0]   alloc_onehot_s;
    logic [NUM_RS-1:0]   load_s;
    logic [NUM_RS-1:0]   free_s;
    logic [NUM_RS-1:0]   use_en_s;
    logic                issue_valid_s;
    logic [IDX_BITS-1:0] issue_idx_s;

    logic [IDX_BITS-1:0] pick_start_s;
    logic [NUM_RS-1:0]   pick_excl_s;
    logic                pick_valid_s;
    logic [IDX_BITS-1:0] pick_idx_s;

    // Allocation: isolate the lowest avail bit; freed entries still read as busy this cycle.
    always_comb begin
        alloc_onehot_s = bus.rs_avail_in & (~bus.rs_avail_in + NUM_RS'(1));
        stall_s        = bus.flush_in | ~(|bus.rs_avail_in);
        if (bus.dispatch_valid_in && !stall_s) begin
            load_s = alloc_onehot_s;
        end else begin
            load_s = {NUM_RS{1'b0}};
        end
    end

    // While issuing, the next winner is searched after the current entry and excludes it.
    always_comb begin
        if (state_r == ISSUE) begin
            pick_start_s = idx_inc(sel_idx_r);
            pick_excl_s  = idx_onehot(sel_idx_r);
        end else begin
            pick_start_s = rr_ptr_r;
            pick_excl_s  = {NUM_RS{1'b0}};
        end
    end

    rs_issue_scheduler_rr_picker u_rr_picker (
        .req_s     (bus.rs_ready_in),
        .start_s   (pick_start_s),
        .exclude_s (pick_excl_s),
        .valid_s   (pick_valid_s),
        .idx_s     (pick_idx_s)
    );

    // Issue FSM next-state and handshake outputs; flush overrides everything.
    always_comb begin
        state_nxt_s   = state_r;
        sel_idx_nxt_s = sel_idx_r;
        rr_ptr_nxt_s  = rr_ptr_r;
        free_s        = {NUM_RS{1'b0}};
        use_en_s      = {NUM_RS{1'b0}};
        issue_valid_s = 1'b0;
        issue_idx_s   = IDX_BITS'(0);
        if (bus.flush_in) begin
            free_s      = ~bus.rs_avail_in;
            state_nxt_s = IDLE;
        end else begin
            case (state_r)
                IDLE: begin
                    if (pick_valid_s) begin
                        sel_idx_nxt_s = pick_idx_s;
                        state_nxt_s   = ISSUE;
                    end else begin
                        state_nxt_s   = IDLE;
                    end
                end
                ISSUE: begin
                    issue_valid_s = 1'b1;
                    issue_idx_s   = sel_idx_r;
                    use_en_s      = idx_onehot(sel_idx_r);
                    if (bus.fu_ready_in) begin
                        free_s       = idx_onehot(sel_idx_r);
                        rr_ptr_nxt_s = idx_inc(sel_idx_r);
                        if (pick_valid_s) begin
                            sel_idx_nxt_s = pick_idx_s;
                            state_nxt_s   = ISSUE;
                        end else begin
                            state_nxt_s   = IDLE;
                        end
                    end else begin
                        state_nxt_s = ISSUE;
                    end
                end
                default: begin
                    state_nxt_s = IDLE;
                end
            endcase
        end
    end

    // Occupancy tracks load/free strobes and saturates at both ends.
    always_comb begin
        if (bus.flush_in) begin
            occ_nxt_s = CNT_BITS'(0);
        end else if ((|load_s) && !(|free_s) && (occ_r != CNT_BITS'(NUM_RS))) begin
            occ_nxt_s = occ_r + CNT_BITS'(1);
        end else if (!(|load_s) && (|free_s) && (occ_r != CNT_BITS'(0))) begin
            occ_nxt_s = occ_r - CNT_BITS'(1);
        end else begin
            occ_nxt_s = occ_r;
        end
    end

    // State, selection, round-robin pointer and occupancy registers.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_r   <= IDLE;
            sel_idx_r <= IDX_BITS'(0);
            rr_ptr_r  <= IDX_BITS'(0);
            occ_r     <= CNT_BITS'(0);
        end else begin
            state_r   <= state_nxt_s;
            sel_idx_r <= sel_idx_nxt_s;
            rr_ptr_r  <= rr_ptr_nxt_s;
            occ_r     <= occ_nxt_s;
        end
    end

    // Strobes are quiesced while reset is held so the bank sees no load/free activity.
    always_comb begin
        if (!reset) begin
            bus.dispatch_stall_out = 1'b1;
            bus.rs_load_out        = {NUM_RS{1'b0}};
            bus.rs_free_out        = {NUM_RS{1'b0}};
            bus.rs_use_enable_out  = {NUM_RS{1'b0}};
            bus.issue_valid_out    = 1'b0;
            bus.issue_idx_out      = IDX_BITS'(0);
        end else begin
            bus.dispatch_stall_out = stall_s;
            bus.rs_load_out        = load_s;
            bus.rs_free_out        = free_s;
            bus.rs_use_enable_out  = use_en_s;
            bus.issue_valid_out    = issue_valid_s;
            bus.issue_idx_out      = issue_idx_s;
        end
    end

    assign bus.occupancy_out = occ_r;

endmodule

// File: tb/tb_rs_issue_scheduler.sv
// Self-checking bench: a reservation-station bank model drives avail/ready, and an
// index-level reference model predicts scheduler outputs each cycle.
module tb_rs_issue_scheduler;
    import rs_issue_scheduler_pkg::*;

    logic clock;
    logic reset;
    rs_issue_scheduler_if bus();

    rs_issue_scheduler dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int tests_run;
    int tests_failed;

    // Bank model: which entries hold an instruction and which have both operands.
    logic [NUM_RS-1:0] env_busy;
    logic [NUM_RS-1:0] env_opv;
    logic              load_ready;

    // Reference scheduler state, in plain integers.
    bit m_presenting;
    int m_sel;
    int m_ptr;
    int m_occ;

    logic                exp_stall;
    logic [NUM_RS-1:0]   exp_load;
    logic [NUM_RS-1:0]   exp_free;
    logic [NUM_RS-1:0]   exp_use;
    logic                exp_valid;
    logic [IDX_BITS-1:0] exp_idx;
    logic [CNT_BITS-1:0] exp_occ;

    task automatic drive_env();
        bus.rs_avail_in = ~env_busy;
        bus.rs_ready_in = env_busy & env_opv;
    endtask

    function automatic int find_rr(int start, int skip);
        for (int k = 0; k < NUM_RS; k++) begin
            int j;
            j = (start + k) % NUM_RS;
            if (env_busy[j] && env_opv[j] && j != skip) return j;
        end
        return -1;
    endfunction

    task automatic model_outputs();
        int first;
        exp_load  = {NUM_RS{1'b0}};
        exp_free  = {NUM_RS{1'b0}};
        exp_use   = {NUM_RS{1'b0}};
        exp_valid = 1'b0;
        exp_idx   = IDX_BITS'(0);
        exp_stall = bus.flush_in || (env_busy == {NUM_RS{1'b1}});
        first = -1;
        for (int i = 0; i < NUM_RS; i++) if (!env_busy[i] && first < 0) first = i;
        if (bus.dispatch_valid_in && !exp_stall) exp_load[first] = 1'b1;
        if (bus.flush_in) begin
            exp_free = env_busy;
        end else if (m_presenting) begin
            exp_valid        = 1'b1;
            exp_idx          = IDX_BITS'(m_sel);
            exp_use[m_sel]   = 1'b1;
            if (bus.fu_ready_in) exp_free[m_sel] = 1'b1;
        end
        exp_occ = CNT_BITS'(m_occ);
    endtask

    task automatic model_advance();
        int w;
        model_outputs();
        if (bus.flush_in) begin
            m_presenting = 1'b0;
        end else if (m_presenting) begin
            if (bus.fu_ready_in) begin
                m_ptr = (m_sel + 1) % NUM_RS;
                w = find_rr(m_sel + 1, m_sel);
                if (w >= 0) m_sel = w;
                else m_presenting = 1'b0;
            end
        end else begin
            w = find_rr(m_ptr, -1);
            if (w >= 0) begin
                m_presenting = 1'b1;
                m_sel = w;
            end
        end
        for (int i = 0; i < NUM_RS; i++) begin
            if (exp_free[i]) begin env_busy[i] = 1'b0; env_opv[i] = 1'b0; end
            if (exp_load[i]) begin env_busy[i] = 1'b1; env_opv[i] = load_ready; end
        end
        m_occ = $countones(env_busy);
    endtask

    task automatic tick();
        model_advance();
        @(posedge clock);
        #1;
        drive_env();
    endtask

    task automatic do_reset();
        reset = 1'b0;
        bus.dispatch_valid_in = 1'b0;
        bus.fu_ready_in = 1'b0;
        bus.flush_in = 1'b0;
        env_busy = {NUM_RS{1'b0}};
        env_opv = {NUM_RS{1'b0}};
        load_ready = 1'b0;
        m_presenting = 1'b0;
        m_sel = 0; m_ptr = 0; m_occ = 0;
        drive_env();
        repeat (2) @(posedge clock);
        #1;
        reset = 1'b1;
        #1;
    endtask

    task automatic fill_bank();
        bus.dispatch_valid_in = 1'b1;
        repeat (NUM_RS) tick();
        bus.dispatch_valid_in = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        bus.dispatch_valid_in = 1'b1;
        repeat (3) tick();
        bus.dispatch_valid_in = 1'b0;
        env_opv = 4'b0100;
        drive_env();
        tick();
        #1;
        tests_run++;
        if (bus.issue_valid_out !== 1'b1 || bus.issue_idx_out !== 2'd2) begin
            tests_failed++;
            $display("FAIL reset_setup: valid=%b idx=%0d, want valid=1 idx=2", bus.issue_valid_out, bus.issue_idx_out);
        end
        bus.dispatch_valid_in = 1'b1;
        bus.flush_in = 1'b1;
        reset = 1'b0;
        #1;
        tests_run++;
        if ({bus.issue_valid_out, bus.occupancy_out, bus.rs_use_enable_out, bus.dispatch_stall_out,
             bus.rs_load_out, bus.rs_free_out, bus.issue_idx_out} !== {1'b0, 3'd0, 4'b0000, 1'b1, 4'b0000, 4'b0000, 2'd0}) begin
            tests_failed++;
            $display("FAIL reset_outputs: valid=%b occ=%0d use=%b stall=%b load=%b free=%b idx=%0d, want 0 0 0000 1 0000 0000 0",
                     bus.issue_valid_out, bus.occupancy_out, bus.rs_use_enable_out, bus.dispatch_stall_out,
                     bus.rs_load_out, bus.rs_free_out, bus.issue_idx_out);
        end
        do_reset();
    endtask

    task automatic test_alloc();
        logic [NUM_RS-1:0] tbl [4];
        tbl = '{4'b0001, 4'b0010, 4'b0100, 4'b1000};
        do_reset();
        bus.dispatch_valid_in = 1'b1;
        for (int k = 0; k < 4; k++) begin
            #1;
            tests_run++;
            if (bus.rs_load_out !== tbl[k] || bus.dispatch_stall_out !== 1'b0) begin
                tests_failed++;
                $display("FAIL alloc_load[%0d]: load=%b stall=%b, want load=%b stall=0", k, bus.rs_load_out, bus.dispatch_stall_out, tbl[k]);
            end
            tick();
        end
        #1;
        tests_run++;
        if (bus.dispatch_stall_out !== 1'b1 || bus.rs_load_out !== 4'b0000 || bus.occupancy_out !== 3'd4) begin
            tests_failed++;
            $display("FAIL alloc_full: stall=%b load=%b occ=%0d, want 1 0000 4", bus.dispatch_stall_out, bus.rs_load_out, bus.occupancy_out);
        end
        bus.dispatch_valid_in = 1'b0;
    endtask

    task automatic test_back_to_back();
        int seq [5];
        seq = '{0, 1, 2, 3, 0};
        do_reset();
        fill_bank();
        bus.dispatch_valid_in = 1'b1;
        load_ready = 1'b1;
        env_opv = 4'b1111;
        bus.fu_ready_in = 1'b1;
        drive_env();
        #1;
        tests_run++;
        if (bus.issue_valid_out !== 1'b0) begin
            tests_failed++;
            $display("FAIL b2b_idle: valid=%b, want 0", bus.issue_valid_out);
        end
        tick();
        for (int k = 0; k < 5; k++) begin
            #1;
            tests_run++;
            if (bus.issue_valid_out !== 1'b1 || bus.issue_idx_out !== IDX_BITS'(seq[k]) ||
                bus.rs_free_out !== idx_onehot(IDX_BITS'(seq[k]))) begin
                tests_failed++;
                $display("FAIL b2b_issue[%0d]: valid=%b idx=%0d free=%b, want valid=1 idx=%0d", k,
                         bus.issue_valid_out, bus.issue_idx_out, bus.rs_free_out, seq[k]);
            end
            tick();
        end
        bus.fu_ready_in = 1'b0;
        bus.dispatch_valid_in = 1'b0;
        load_ready = 1'b0;
    endtask

    task automatic test_hold();
        do_reset();
        fill_bank();
        env_opv = 4'b0101;
        drive_env();
        tick();
        for (int k = 0; k < 4; k++) begin
            bus.fu_ready_in = (k == 3);
            #1;
            tests_run++;
            if (bus.issue_valid_out !== 1'b1 || bus.issue_idx_out !== 2'd0 ||
                bus.rs_free_out !== ((k == 3) ? 4'b0001 : 4'b0000)) begin
                tests_failed++;
                $display("FAIL hold[%0d]: valid=%b idx=%0d free=%b, want valid=1 idx=0", k,
                         bus.issue_valid_out, bus.issue_idx_out, bus.rs_free_out);
            end
            tick();
        end
        bus.fu_ready_in = 1'b0;
        #1;
        tests_run++;
        if (bus.issue_valid_out !== 1'b1 || bus.issue_idx_out !== 2'd2) begin
            tests_failed++;
            $display("FAIL hold_next: valid=%b idx=%0d, want valid=1 idx=2", bus.issue_valid_out, bus.issue_idx_out);
        end
    endtask

    // Leaves entries 0,2,3 busy with entry 3 being presented and occupancy 3.
    task automatic setup_three_busy();
        do_reset();
        fill_bank();
        env_opv = 4'b0010;
        drive_env();
        tick();
        bus.fu_ready_in = 1'b1;
        tick();
        bus.fu_ready_in = 1'b0;
        env_opv = 4'b1000;
        drive_env();
        tick();
        #1;
        tests_run++;
        if (bus.issue_idx_out !== 2'd3 || bus.issue_valid_out !== 1'b1 || bus.occupancy_out !== 3'd3 ||
            bus.rs_avail_in !== 4'b0010) begin
            tests_failed++;
            $display("FAIL setup3: idx=%0d valid=%b occ=%0d, want idx=3 valid=1 occ=3",
                     bus.issue_idx_out, bus.issue_valid_out, bus.occupancy_out);
        end
    endtask

    task automatic test_flush();
        setup_three_busy();
        bus.flush_in = 1'b1;
        bus.dispatch_valid_in = 1'b1;
        bus.fu_ready_in = 1'b1;
        #1;
        tests_run++;
        if (bus.rs_free_out !== 4'b1101 || bus.issue_valid_out !== 1'b0 || bus.rs_use_enable_out !== 4'b0000 ||
            bus.rs_load_out !== 4'b0000 || bus.dispatch_stall_out !== 1'b1) begin
            tests_failed++;
            $display("FAIL flush_strobes: free=%b valid=%b use=%b load=%b stall=%b, want 1101 0 0000 0000 1",
                     bus.rs_free_out, bus.issue_valid_out, bus.rs_use_enable_out, bus.rs_load_out, bus.dispatch_stall_out);
        end
        tick();
        bus.flush_in = 1'b0;
        bus.dispatch_valid_in = 1'b0;
        bus.fu_ready_in = 1'b0;
        #1;
        tests_run++;
        if (bus.issue_valid_out !== 1'b0 || bus.occupancy_out !== 3'd0) begin
            tests_failed++;
            $display("FAIL flush_after: valid=%b occ=%0d, want 0 0", bus.issue_valid_out, bus.occupancy_out);
        end
    endtask

    task automatic test_simultaneous();
        setup_three_busy();
        bus.dispatch_valid_in = 1'b1;
        bus.fu_ready_in = 1'b1;
        #1;
        tests_run++;
        if (bus.rs_load_out !== 4'b0010 || bus.rs_free_out !== 4'b1000) begin
            tests_failed++;
            $display("FAIL simul_strobes: load=%b free=%b, want 0010 1000", bus.rs_load_out, bus.rs_free_out);
        end
        tick();
        bus.dispatch_valid_in = 1'b0;
        bus.fu_ready_in = 1'b0;
        #1;
        tests_run++;
        if (bus.occupancy_out !== 3'd3) begin
            tests_failed++;
            $display("FAIL simul_occ: occ=%0d, want 3", bus.occupancy_out);
        end
    endtask

    task automatic test_random();
        do_reset();
        for (int c = 0; c < 600; c++) begin
            bus.dispatch_valid_in = 1'($urandom_range(0, 1));
            bus.fu_ready_in = ($urandom_range(0, 3) != 0);
            bus.flush_in = ($urandom_range(0, 19) == 0);
            load_ready = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 2) == 0) env_opv = env_opv | (NUM_RS'($urandom_range(0, 15)) & env_busy);
            drive_env();
            #1;
            model_outputs();
            tests_run++;
            if ({bus.dispatch_stall_out, bus.rs_load_out, bus.rs_free_out, bus.rs_use_enable_out,
                 bus.issue_valid_out, bus.issue_idx_out, bus.occupancy_out} !==
                {exp_stall, exp_load, exp_free, exp_use, exp_valid, exp_idx, exp_occ}) begin
                tests_failed++;
                $display("FAIL random[%0d]: stall/load/free/use/valid/idx/occ got %b %b %b %b %b %0d %0d want %b %b %b %b %b %0d %0d",
                         c, bus.dispatch_stall_out, bus.rs_load_out, bus.rs_free_out, bus.rs_use_enable_out,
                         bus.issue_valid_out, bus.issue_idx_out, bus.occupancy_out,
                         exp_stall, exp_load, exp_free, exp_use, exp_valid, exp_idx, exp_occ);
            end
            tick();
        end
    endtask

    initial begin
        tests_run = 0;
        tests_failed = 0;
        test_reset();
        test_alloc();
        test_back_to_back();
        test_hold();
        test_flush();
        test_simultaneous();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
